// File: rtl/gate_test_seq.sv
// Exhaustive sequencer for one combinational gate: walks every input vector, settles, checks
// the gate output against a truth table and reports error count, first failing vector and pass.
module gate_test_seq #(
  parameter int                  N_IN          = 2,
  parameter logic [2**N_IN-1:0]  FUNC          = 4'b1000,
  parameter int                  SETTLE_CYCLES = 2,
  parameter int                  ERR_W         = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [N_IN-1:0]  dut_in,
  input  logic             dut_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [N_IN-1:0]  fail_vec,
  output logic             fail_valid
);

  localparam int               CNT_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [N_IN-1:0]  VEC_LAST = {N_IN{1'b1}};
  localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};

  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;

  state_t           state_q, state_d;
  logic [N_IN-1:0]  vec_q, vec_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [N_IN-1:0]  fail_vec_q, fail_vec_d;
  logic             fail_valid_q, fail_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             mismatch;
  logic [ERR_W-1:0] err_next;

  always_comb begin
    mismatch = (dut_out != FUNC[vec_q]);
    err_next = err_q;
    if (mismatch && (err_q != ERR_MAX)) begin
      err_next = err_q + ERR_W'(1);
    end
  end

  // Outputs are computed for the next state so busy/done line up with the state they describe.
  always_comb begin
    state_d      = state_q;
    vec_d        = vec_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    fail_vec_d   = fail_vec_q;
    fail_valid_d = fail_valid_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    pass_d       = pass_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d      = SETTLE;
          vec_d        = '0;
          cnt_d        = '0;
          err_d        = '0;
          fail_vec_d   = '0;
          fail_valid_d = 1'b0;
          pass_d       = 1'b0;
          busy_d       = 1'b1;
        end
      end
      SETTLE: begin
        if (cnt_q == CNT_LAST) begin
          state_d = CHECK;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      CHECK: begin
        err_d = err_next;
        if (mismatch && !fail_valid_q) begin
          fail_vec_d   = vec_q;
          fail_valid_d = 1'b1;
        end
        if (vec_q == VEC_LAST) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_next == '0);
        end else begin
          state_d = SETTLE;
          vec_d   = vec_q + N_IN'(1);
          cnt_d   = '0;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      vec_q        <= '0;
      cnt_q        <= '0;
      err_q        <= '0;
      fail_vec_q   <= '0;
      fail_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      vec_q        <= vec_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      fail_vec_q   <= fail_vec_d;
      fail_valid_q <= fail_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
    end
  end

  // The vector register itself drives the gate so dut_in only moves when vec does.
  assign dut_in     = vec_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_cnt    = err_q;
  assign fail_vec   = fail_vec_q;
  assign fail_valid = fail_valid_q;

endmodule

// File: tb/tb_gate_test_seq.sv
// Directed bench for gate_test_seq: three instances (defaults, ERR_W=1, SETTLE_CYCLES=3) share
// start/reset and each drives its own behavioural gate model selected by gate_mode.
module tb_gate_test_seq;

  localparam int M_GOOD   = 0;
  localparam int M_STUCK0 = 1;
  localparam int M_STUCK1 = 2;
  localparam int M_DELAY  = 3;

  logic clk = 1'b0;
  logic rst;
  logic start;
  int   gate_mode;
  int   checks = 0;
  int   errors = 0;

  logic [1:0] in_m, in_e, in_s;
  logic       out_m, out_e, out_s;
  logic       busy_m, busy_e, busy_s;
  logic       done_m, done_e, done_s;
  logic       pass_m, pass_e, pass_s;
  logic [3:0] err_m, err_s;
  logic [0:0] err_e;
  logic [1:0] fv_m, fv_e, fv_s;
  logic       fval_m, fval_e, fval_s;
  logic [2:0] dly_m, dly_e, dly_s;

  always #5 clk = ~clk;

  gate_test_seq dut (
    .clk(clk), .rst(rst), .start(start), .dut_in(in_m), .dut_out(out_m), .busy(busy_m),
    .done(done_m), .pass(pass_m), .err_cnt(err_m), .fail_vec(fv_m), .fail_valid(fval_m)
  );

  gate_test_seq #(.ERR_W(1)) dut_e1 (
    .clk(clk), .rst(rst), .start(start), .dut_in(in_e), .dut_out(out_e), .busy(busy_e),
    .done(done_e), .pass(pass_e), .err_cnt(err_e), .fail_vec(fv_e), .fail_valid(fval_e)
  );

  gate_test_seq #(.SETTLE_CYCLES(3)) dut_s3 (
    .clk(clk), .rst(rst), .start(start), .dut_in(in_s), .dut_out(out_s), .busy(busy_s),
    .done(done_s), .pass(pass_s), .err_cnt(err_s), .fail_vec(fv_s), .fail_valid(fval_s)
  );

  // Three-cycle delayed AND: dly[2] is the AND of the inputs seen three rising edges ago.
  always_ff @(posedge clk) begin
    dly_m <= {dly_m[1:0], &in_m};
    dly_e <= {dly_e[1:0], &in_e};
    dly_s <= {dly_s[1:0], &in_s};
  end

  function automatic logic gateModel(input int mode, input logic [1:0] v, input logic d);
    case (mode)
      M_STUCK0: return 1'b0;
      M_STUCK1: return 1'b1;
      M_DELAY:  return d;
      default:  return v[0] & v[1];
    endcase
  endfunction

  always_comb begin
    out_m = gateModel(gate_mode, in_m, dly_m[2]);
    out_e = gateModel(gate_mode, in_e, dly_e[2]);
    out_s = gateModel(gate_mode, in_s, dly_s[2]);
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One-cycle start pulse; returns at the falling edge of the first cycle after E0.
  task automatic applyStimulus();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  // Full run long enough for every instance (the S=3 one finishes in cycle 17).
  task automatic runOne();
    applyStimulus();
    repeat (19) @(negedge clk);
  endtask

  task automatic resetDut();
    @(negedge clk) rst = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    gate_mode = M_GOOD;
    @(negedge clk);
    checkOutput("reset dut_in", in_m, 0);
    checkOutput("reset busy", busy_m, 0);
    checkOutput("reset done", done_m, 0);
    checkOutput("reset pass", pass_m, 0);
    checkOutput("reset err_cnt", err_m, 0);
    checkOutput("reset fail_valid", fval_m, 0);
    checkOutput("reset fail_vec", fv_m, 0);
    @(negedge clk) rst = 1'b0;

    $display("[TB] T1 good AND model");
    applyStimulus();
    for (int c = 1; c <= 20; c++) begin
      if (c <= 14) begin
        checkOutput($sformatf("T1 dut_in c%0d", c), in_m, (c <= 12) ? (c - 1) / 3 : 3);
        checkOutput($sformatf("T1 busy c%0d", c), busy_m, (c <= 12) ? 1 : 0);
        checkOutput($sformatf("T1 done c%0d", c), done_m, (c == 13) ? 1 : 0);
      end
      checkOutput($sformatf("T1 s3 done c%0d", c), done_s, (c == 17) ? 1 : 0);
      if (c < 20) @(negedge clk);
    end
    checkOutput("T1 pass", pass_m, 1);
    checkOutput("T1 err_cnt", err_m, 0);
    checkOutput("T1 fail_valid", fval_m, 0);
    checkOutput("T1 e1 pass", pass_e, 1);
    checkOutput("T1 e1 busy", busy_e, 0);
    checkOutput("T1 e1 dut_in held", in_e, 3);
    checkOutput("T1 s3 pass", pass_s, 1);
    checkOutput("T1 s3 busy", busy_s, 0);

    $display("[TB] T2 stuck-at-0 with stray start while busy");
    gate_mode = M_STUCK0;
    applyStimulus();
    for (int c = 1; c <= 20; c++) begin
      if (c == 5) start = 1'b1;
      if (c == 6) start = 1'b0;
      if (c <= 14) begin
        checkOutput($sformatf("T2 done c%0d", c), done_m, (c == 13) ? 1 : 0);
        checkOutput($sformatf("T2 busy c%0d", c), busy_m, (c <= 12) ? 1 : 0);
      end
      if (c < 20) @(negedge clk);
    end
    checkOutput("T2 err_cnt", err_m, 1);
    checkOutput("T2 fail_vec", fv_m, 3);
    checkOutput("T2 fail_valid", fval_m, 1);
    checkOutput("T2 pass", pass_m, 0);
    checkOutput("T2 s3 err_cnt", err_s, 1);
    checkOutput("T2 s3 fail_vec", fv_s, 3);
    checkOutput("T2 e1 err_cnt", err_e, 1);

    $display("[TB] T3 stuck-at-1");
    gate_mode = M_STUCK1;
    runOne();
    checkOutput("T3 err_cnt", err_m, 3);
    checkOutput("T3 fail_vec", fv_m, 0);
    checkOutput("T3 fail_valid", fval_m, 1);
    checkOutput("T3 pass", pass_m, 0);
    checkOutput("T3 e1 err_cnt saturated", err_e, 1);
    checkOutput("T3 e1 fail_vec", fv_e, 0);
    checkOutput("T3 e1 fail_valid", fval_e, 1);
    checkOutput("T3 e1 pass", pass_e, 0);

    $display("[TB] T4 three-cycle delayed AND");
    gate_mode = M_DELAY;
    resetDut();
    runOne();
    checkOutput("T4 S2 err_cnt", err_m, 1);
    checkOutput("T4 S2 fail_vec", fv_m, 3);
    checkOutput("T4 S2 pass", pass_m, 0);
    checkOutput("T4 S3 pass", pass_s, 1);
    checkOutput("T4 S3 err_cnt", err_s, 0);
    checkOutput("T4 S3 fail_valid", fval_s, 0);

    $display("[TB] T5 asynchronous reset mid-run");
    gate_mode = M_STUCK1;
    applyStimulus();
    repeat (6) @(negedge clk);
    checkOutput("T5 pre dut_in", in_m, 2);
    checkOutput("T5 pre err_cnt", err_m, 2);
    checkOutput("T5 pre fail_valid", fval_m, 1);
    rst = 1'b1;
    #1;
    checkOutput("T5 rst dut_in", in_m, 0);
    checkOutput("T5 rst busy", busy_m, 0);
    checkOutput("T5 rst err_cnt", err_m, 0);
    checkOutput("T5 rst fail_valid", fval_m, 0);
    checkOutput("T5 rst done", done_m, 0);
    @(negedge clk) rst = 1'b0;
    gate_mode = M_GOOD;
    runOne();
    checkOutput("T5 rerun pass", pass_m, 1);
    checkOutput("T5 rerun err_cnt", err_m, 0);

    $display("[TB] T6 start held high");
    gate_mode = M_STUCK0;
    @(negedge clk) start = 1'b1;
    for (int c = 1; c <= 45; c++) begin
      @(negedge clk);
      if (c == 40) start = 1'b0;
      checkOutput($sformatf("T6 done c%0d", c), done_m,
                  (c == 13 || c == 27 || c == 41) ? 1 : 0);
      if (c == 14) checkOutput("T6 err_cnt end run1", err_m, 1);
      if (c == 15) checkOutput("T6 err_cnt cleared run2", err_m, 0);
      if (c == 45) checkOutput("T6 idle busy", busy_m, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
